// File: rtl/tff_pkg.sv
// tff_pkg: shared width default and direction encodings for the T flip-flop counter
package tff_pkg;
    localparam int DEFAULT_WIDTH = 4;
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/tff_cell.sv
// tff_cell: single T flip-flop with asynchronous active-low clear
module tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);
    // toggle on t, clear immediately when reset is low
    always_ff @(posedge clk or negedge reset)
        if (!reset) q <= 1'b0;
        else q <= q ^ t;
endmodule

// File: rtl/tff_updown_counter.sv
// tff_updown_counter: loadable up/down modulo-(limit+1) counter built from T flip-flops
module tff_updown_counter
    import tff_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] q,
    output logic             tc
);
    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] t;
    logic             wrap;
    logic             next_tc;

    // next count from load/wrap/step rules; toggles are the bits that change
    always_comb begin
        wrap    = en & ((up == DIR_UP) ? (q >= limit) : (q == '0));
        next_q  = load ? d :
                  !en  ? q :
                  wrap ? ((up == DIR_UP) ? '0 : limit) :
                  (up == DIR_UP) ? q + WIDTH'(1) : q - WIDTH'(1);
        next_tc = !load & wrap;
        t       = q ^ next_q;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tff_cell u_cell (
            .clk  (clk),
            .reset(reset),
            .t    (t[i]),
            .q    (q[i])
        );
    end

    // terminal-count pulse registered alongside the wrapped count
    always_ff @(posedge clk or negedge reset)
        if (!reset) tc <= 1'b0;
        else tc <= next_tc;
endmodule

// File: tb/tb_tff_updown_counter.sv
// tb_tff_updown_counter: directed scenarios plus random stimulus against a behavioural model
module tb_tff_updown_counter;
    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         en = 1'b0;
    logic         up = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] d = '0;
    logic [W-1:0] limit = '0;
    logic [W-1:0] q;
    logic         tc;

    int checks = 0;
    int errors = 0;
    int mq = 0;
    int mtc = 0;

    tff_updown_counter #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .up   (up),
        .load (load),
        .d    (d),
        .limit(limit),
        .q    (q),
        .tc   (tc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // one clock edge with the given inputs; the model applies the rules to the sampled values
    task automatic step(input logic e, input logic u, input logic l, input int dv, input int lim, input string tag);
        en = e;
        up = u;
        load = l;
        d = dv[W-1:0];
        limit = lim[W-1:0];
        @(posedge clk);
        mtc = 0;
        if (l) mq = dv % M;
        else if (e && u) begin
            if (mq >= lim) begin mq = 0; mtc = 1; end
            else mq = (mq + 1) % M;
        end else if (e) begin
            if (mq == 0) begin mq = lim % M; mtc = 1; end
            else mq = mq - 1;
        end
        #1;
        check({tag, " q"}, int'(q), mq);
        check({tag, " tc"}, int'(tc), mtc);
    endtask

    // asynchronous reset pulse placed mid-cycle, checked before the next edge
    task automatic async_reset(input string tag);
        #3 reset = 1'b0;
        #1;
        mq = 0;
        mtc = 0;
        check({tag, " q"}, int'(q), 0);
        check({tag, " tc"}, int'(tc), 0);
        #2 reset = 1'b1;
    endtask

    initial begin
        #2;
        check("reset q", int'(q), 0);
        check("reset tc", int'(tc), 0);
        #5;
        check("reset edge q", int'(q), 0);
        check("reset edge tc", int'(tc), 0);
        #3 reset = 1'b1;

        for (int i = 0; i < 17; i++) step(1, 1, 0, 0, 15, "full up");
        async_reset("rst a");
        for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 9, "mod up");
        async_reset("rst b");
        for (int i = 0; i < 11; i++) step(1, 0, 0, 0, 9, "down");
        step(0, 1, 1, 12, 9, "load above");
        step(1, 1, 0, 0, 9, "above up wrap");
        step(1, 1, 1, 12, 9, "load above2");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 9, "above down");
        async_reset("rst c");
        for (int i = 0; i < 7; i++) step(1, 1, 0, 0, 15, "to seven");
        check("at seven", int'(q), 7);
        async_reset("mid reset");
        for (int i = 0; i < 2; i++) step(1, 1, 0, 0, 15, "resume");
        check("resumed two", int'(q), 2);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 3, 15, "hold");
        step(0, 1, 1, 5, 15, "load no en");
        step(1, 1, 1, 11, 15, "load wins");
        step(1, 0, 1, 0, 0, "load zero");
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, "lim0 up");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, "lim0 down");
        step(1, 0, 0, 0, 15, "down wrap max");
        step(1, 1, 0, 0, 15, "up wrap max");

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) async_reset("rand rst");
            else step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 9) == 0, int'($urandom_range(0, M - 1)),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, M - 1)) : 9, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
